// File: rtl/nibble_add_scheduler_pkg.sv
// Shared types and constants for the nibble-serial add/sub scheduler.
// Holds the FSM state enum, nibble-count helper and requester ids.
package nibble_add_scheduler_pkg;

   localparam int DEF_WIDTH = 16;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   function automatic int nib_of(input int w);
      return w / 4;
   endfunction

endpackage

// File: rtl/nibble_add_scheduler_if.sv
// Request/response bundle between two clients and the scheduler.
// Ports: reqN_{valid,ready,a,b,sub}, rsp_{valid,ready,id,sum,cout,ovf}, busy.
interface nibble_add_scheduler_if #(
   parameter int WIDTH = 16
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic             req0_sub;

   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic             req1_sub;

   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_sum;
   logic             rsp_cout;
   logic             rsp_ovf;

   logic             busy;

   modport master (
      output req0_valid, req0_a, req0_b, req0_sub,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_sub,
      input  req1_ready,
      input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf,
      output rsp_ready,
      input  busy
   );

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_sub,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_sub,
      output req1_ready,
      output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf,
      input  rsp_ready,
      output busy
   );

endinterface

// File: rtl/adder4_ripple_carry.sv
// Existing 4-bit ripple-carry adder slice shared by the scheduler.
// Ports: i_a, i_b, i_cin in; o_sum, o_cout out.
module adder4_ripple_carry (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_cin,
   output logic [3:0] o_sum,
   output logic       o_cout
);

   logic [4:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar g = 0; g < 4; g++) begin : g_fa
      assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
      assign w_c[g+1]  = (i_a[g] & i_b[g]) |
                         (w_c[g] & (i_a[g] ^ i_b[g]));
   end

   assign o_cout = w_c[4];

endmodule

// File: rtl/nibble_add_scheduler.sv
// Two-client round-robin add/sub using one 4-bit slice, LSB nibble first.
// Ports: clk, rst_n, bus (slave side of nibble_add_scheduler_if).
module nibble_add_scheduler
   import nibble_add_scheduler_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   nibble_add_scheduler_if.slave  bus
);

   localparam int NIB = nib_of(WIDTH);
   localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_ptr;
   logic             r_id;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic [KW-1:0]    r_k;
   logic             r_carry;
   logic             r_cout;
   logic             r_ovf;

   logic             w_gnt0;
   logic             w_gnt1;
   logic             w_acc;
   logic             w_sub_sel;
   logic [WIDTH-1:0] w_a_sel;
   logic [WIDTH-1:0] w_b_sel;
   logic [3:0]       w_na;
   logic [3:0]       w_nb;
   logic [3:0]       w_ns;
   logic             w_nc;
   logic             w_last;
   logic             w_ovf;

   // r_ptr holds the last granted id; a tie goes to the other one.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (r_state == S_IDLE) begin
         if (bus.req0_valid && bus.req1_valid) begin
            if (r_ptr == REQ0) w_gnt1 = 1'b1;
            else               w_gnt0 = 1'b1;
         end else if (bus.req0_valid) begin
            w_gnt0 = 1'b1;
         end else if (bus.req1_valid) begin
            w_gnt1 = 1'b1;
         end
      end
   end

   assign w_acc     = w_gnt0 | w_gnt1;
   assign w_sub_sel = w_gnt1 ? bus.req1_sub : bus.req0_sub;
   assign w_a_sel   = w_gnt1 ? bus.req1_a : bus.req0_a;
   assign w_b_sel   = (w_gnt1 ? bus.req1_b : bus.req0_b) ^
                      {WIDTH{w_sub_sel}};

   assign w_na   = r_a[4*r_k +: 4];
   assign w_nb   = r_b[4*r_k +: 4];
   assign w_last = (r_k == KW'(NIB - 1));

   adder4_ripple_carry u_slice (
      .i_a    (w_na),
      .i_b    (w_nb),
      .i_cin  (r_carry),
      .o_sum  (w_ns),
      .o_cout (w_nc)
   );

   // Same operand signs but a different result sign means overflow.
   assign w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                  (w_ns[3] != r_a[WIDTH-1]);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE: if (w_acc) w_state_nxt = S_RUN;
         S_RUN:  if (w_last) w_state_nxt = S_DONE;
         S_DONE: if (bus.rsp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_ptr   <= REQ1;
         r_id    <= REQ0;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_k     <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_acc) begin
            r_a     <= w_a_sel;
            r_b     <= w_b_sel;
            r_id    <= w_gnt1;
            r_k     <= '0;
            r_carry <= w_sub_sel;
         end
         if (r_state == S_RUN) begin
            r_sum[4*r_k +: 4] <= w_ns;
            r_carry           <= w_nc;
            r_k               <= r_k + KW'(1);
            if (w_last) begin
               r_cout <= w_nc;
               r_ovf  <= w_ovf;
            end
         end
         if (r_state == S_DONE && bus.rsp_ready) begin
            r_ptr <= r_id;
         end
      end
   end

   assign bus.req0_ready = w_gnt0;
   assign bus.req1_ready = w_gnt1;
   assign bus.rsp_valid  = (r_state == S_DONE);
   assign bus.rsp_id     = r_id;
   assign bus.rsp_sum    = r_sum;
   assign bus.rsp_cout   = r_cout;
   assign bus.rsp_ovf    = r_ovf;
   assign bus.busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_nibble_add_scheduler.sv
// Directed bench for nibble_add_scheduler (WIDTH=16).
// Drives both requesters, checks latency, results, arbitration, stall, reset.
module tb_nibble_add_scheduler;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   nibble_add_scheduler_if #(.WIDTH(16)) bus ();

   nibble_add_scheduler #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic issue(input logic id, input logic [15:0] a,
                        input logic [15:0] b, input logic sub);
      @(negedge clk);
      if (id) begin
         bus.req1_valid = 1'b1;
         bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub;
      end else begin
         bus.req0_valid = 1'b1;
         bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub;
      end
      #1;
      chk("acc_ready", id ? bus.req1_ready : bus.req0_ready, 1);
      @(posedge clk);
      #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
   endtask

   // Called 1 time unit after the accept edge.
   task automatic expect_rsp(input string tag, input logic id,
                             input logic [15:0] sum, input logic cout,
                             input logic ovf);
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk);
         #1;
         if (i < 4) chk({tag, "_early"}, bus.rsp_valid, 0);
      end
      chk({tag, "_valid"}, bus.rsp_valid, 1);
      chk({tag, "_id"}, bus.rsp_id, id);
      chk({tag, "_sum"}, bus.rsp_sum, sum);
      chk({tag, "_cout"}, bus.rsp_cout, cout);
      chk({tag, "_ovf"}, bus.rsp_ovf, ovf);
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_taken"}, bus.rsp_valid, 0);
      chk({tag, "_idle"}, bus.busy, 0);
      bus.rsp_ready = 1'b0;
   endtask

   logic [15:0] exp_sum;
   int          ng;
   int          nr;
   logic        gnt_log [8];
   logic        rsp_log [8];

   initial begin
      bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0;
      bus.req0_sub = 0;
      bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0;
      bus.req1_sub = 0;
      bus.rsp_ready = 0;

      #12;
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_sum", bus.rsp_sum, 0);
      chk("rst_id", bus.rsp_id, 0);
      chk("rst_cout", bus.rsp_cout, 0);
      chk("rst_ovf", bus.rsp_ovf, 0);
      chk("rst_rdy0", bus.req0_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(0, 16'h1234, 16'h0FFF, 0);
      chk("run_busy", bus.busy, 1);
      expect_rsp("add1", 0, 16'h2233, 0, 0);
      issue(0, 16'hFFFF, 16'h0001, 0);
      expect_rsp("wrap", 0, 16'h0000, 1, 0);
      issue(0, 16'h7FFF, 16'h0001, 0);
      expect_rsp("povf", 0, 16'h8000, 0, 1);
      issue(0, 16'h0005, 16'h0007, 1);
      expect_rsp("sub1", 0, 16'hFFFE, 0, 0);
      issue(0, 16'h8000, 16'h0001, 1);
      expect_rsp("sub2", 0, 16'h7FFF, 1, 1);

      // Round-robin with both requesters always valid.
      do_reset();
      ng = 0;
      nr = 0;
      @(negedge clk);
      bus.req0_valid = 1; bus.req0_a = 16'h0001;
      bus.req0_b = 16'h0001; bus.req0_sub = 0;
      bus.req1_valid = 1; bus.req1_a = 16'h0010;
      bus.req1_b = 16'h0001; bus.req1_sub = 1;
      bus.rsp_ready = 1;
      for (int c = 0; c < 40; c++) begin
         #1;
         chk("rr_one_ready", bus.req0_ready & bus.req1_ready, 0);
         if ((bus.req0_ready | bus.req1_ready) && ng < 8) begin
            gnt_log[ng] = bus.req1_ready;
            ng++;
         end
         if (bus.rsp_valid && nr < 8) begin
            rsp_log[nr] = bus.rsp_id;
            exp_sum = bus.rsp_id ? 16'h000F : 16'h0002;
            chk("rr_sum", bus.rsp_sum, exp_sum);
            nr++;
         end
         @(negedge clk);
      end
      bus.req0_valid = 0;
      bus.req1_valid = 0;
      repeat (8) @(negedge clk);
      bus.rsp_ready = 0;
      chk("rr_ngrants", ng >= 4, 1);
      chk("rr_nrsp", nr >= 4, 1);
      for (int i = 0; i < 4; i++) begin
         chk("rr_grant", gnt_log[i], i % 2);
         chk("rr_rsp_id", rsp_log[i], i % 2);
      end

      // Hold rsp_ready low in DONE while requester 0 waits.
      issue(1, 16'h00FF, 16'h0001, 0);
      bus.req0_valid = 1; bus.req0_a = 16'h0001;
      bus.req0_b = 16'h0001; bus.req0_sub = 0;
      repeat (4) @(posedge clk);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         chk("stall_valid", bus.rsp_valid, 1);
         chk("stall_sum", bus.rsp_sum, 16'h0100);
         chk("stall_id", bus.rsp_id, 1);
         chk("stall_rdy0", bus.req0_ready, 0);
      end
      @(negedge clk);
      bus.rsp_ready = 1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 0;
      chk("rel_valid", bus.rsp_valid, 0);
      chk("rel_rdy0", bus.req0_ready, 1);
      @(posedge clk);
      #1;
      bus.req0_valid = 0;
      expect_rsp("after", 0, 16'h0002, 0, 0);

      // Reset in the middle of RUN.
      issue(0, 16'h1234, 16'h0FFF, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_valid", bus.rsp_valid, 0);
      chk("mid_rst_sum", bus.rsp_sum, 0);
      chk("mid_rst_id", bus.rsp_id, 0);
      chk("mid_rst_cout", bus.rsp_cout, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         #1;
         chk("no_stale", bus.rsp_valid, 0);
      end
      @(negedge clk);
      bus.req0_valid = 1; bus.req0_a = 16'h7FFF;
      bus.req0_b = 16'h0001; bus.req0_sub = 0;
      bus.req1_valid = 1; bus.req1_a = 16'h0001;
      bus.req1_b = 16'h0001; bus.req1_sub = 0;
      #1;
      chk("tie_rdy0", bus.req0_ready, 1);
      chk("tie_rdy1", bus.req1_ready, 0);
      @(posedge clk);
      #1;
      bus.req0_valid = 0;
      bus.req1_valid = 0;
      expect_rsp("tie", 0, 16'h8000, 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
